digit_scanner: RTL and testbench
================================

# digit_scanner

Parametrised multiplexed display scanner. It drives a one-hot digit select and a per-digit code for an N-digit seven-segment display. A scan prescaler sets the digit rate, and each digit shows one hex nibble of a value snapshot that only updates on frame boundaries, so the display never tears. It adds leading-zero suppression and a frame-counted blink mode. It sits between the ALU/result register and the segment decoder in the display path.

## Interface
- NUM_DIGITS, 4, number of display digits (2..8)
- VALUE_W, 8, displayed value width in bits; nibbles = ceil(VALUE_W/4); digits above that are always blank
- NUM_W, 5, width of the digit code output
- BLANK_CODE, 20, code emitted for a dark digit (must be > 15)
- SCAN_DIV, 1000, CLK cycles per digit slot (>= 1)
- BLINK_FRAMES, 32, frames per blink half-period (>= 1)

- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 forces the idle display
- load  in  1  single-cycle strobe; captures value into the pending register
- value  in  VALUE_W  value to display
- lz_suppress  in  1  1 = blank leading zero nibbles (digit 0 is never suppressed)
- blink  in  1  1 = blink the whole display
- dig  out  NUM_DIGITS  one-hot digit select; bit i selects digit i, where digit 0 is the least significant
- num  out  NUM_W  code for the selected digit: 0..15 or BLANK_CODE
- frame_start  out  1  one-cycle pulse when digit 0 becomes active

## Operation
- State machine with two states:
  - IDLE (en=0): dig = 1, num = BLANK_CODE. The prescaler, index, and blink phase are held at 0.
  - SCAN (en=1): entered the first cycle en=1 is sampled. The first tick occurs SCAN_DIV cycles later.
  - Dropping en returns to IDLE on the next edge, whatever the current slot.
- Prescaler counts 0..SCAN_DIV-1. `tick` is asserted at terminal count and the counter wraps to 0.
- Digit index idx counts 0..NUM_DIGITS-1 and advances on tick, wrapping to 0. When it wraps to 0:
  - snapshot <= pending, or <= value directly if load is high in that same cycle (bypass);
  - frame_start pulses;
  - the blink frame counter increments.
- load outside a wrap cycle updates pending only. The visible digits change at the next frame start.
- Digit code for slot i:
  - i >= nibbles: BLANK_CODE.
  - Otherwise nib = snapshot[4i+3:4i], zero-extended to NUM_W. The top nibble is zero-padded when VALUE_W is not a multiple of 4.
  - With lz_suppress=1 and i>0: BLANK_CODE if every nibble at index >= i is zero.
- Blink:
  - The phase toggles after every BLINK_FRAMES completed frames.
  - While blink=1 and phase=off, num = BLANK_CODE but dig keeps scanning.
  - blink=0 forces the phase to on and clears the frame counter.
- lz_suppress and blink take effect on the next registered update. They are not latched per frame.

## Timing
- Reset values:
  - dig = 1, num = BLANK_CODE, frame_start = 0;
  - pending = 0, snapshot = 0, idx = 0, prescaler = 0, blink phase = on.
- Reset mid-scan: the same values apply immediately (asynchronous). Scanning resumes from digit 0 after release if en=1.
- dig, num, and frame_start are registered.
  - dig/num change on the edge where tick is sampled.
  - dig and num always change on the same edge, so num always matches the digit being selected.
- Slot length is exactly SCAN_DIV cycles. Frame length is NUM_DIGITS*SCAN_DIV cycles.
- Load-to-display latency: at most one frame plus one cycle. With the bypass, it is 1 cycle when load coincides with the wrap tick.
- Two loads within one frame: the last one wins.

## Structure
- Shared display package `disp_pkg` holds:
  - BLANK_CODE default and NUM_W default;
  - the state enum (IDLE, SCAN);
  - a function `nibble_count(VALUE_W)`.
- One natural sub-module, `scan_prescaler`: parametrised terminal-count divider with clear input, producing tick.
- The leading-zero mask is computed combinationally from snapshot as a NUM_DIGITS-bit vector and is part of the top level.

## Test plan
- Reset and idle:
  - with RST_N=0, dig=0001 and num=20;
  - release with en=0 → outputs stay, frame_start never pulses.
- Basic scan (defaults, SCAN_DIV=2):
  - load value=8'hA5, en=1 → after the first frame boundary, num sequence per slot is 5, A, 20, 20 with dig 0001, 0010, 0100, 1000;
  - each slot lasts 2 cycles.
- Tearing:
  - load 8'h12 mid-frame → remaining slots still show the old snapshot;
  - the new nibbles appear from the next frame_start;
  - load on the wrap cycle → digit 0 shows 2 in the next cycle.
- Leading zeros (VALUE_W=16, NUM_DIGITS=6):
  - value=16'h0040, lz_suppress=1 → codes 0, 4, 20, 20, 20, 20;
  - value=0 → 0, 20, 20, 20, 20, 20;
  - lz_suppress=0 → 0, 4, 0, 0, 20, 20.
- Blink (BLINK_FRAMES=2):
  - blink=1 → frames 1–2 lit, frames 3–4 all num=20 with dig still rotating, frame 5 lit;
  - blink=0 mid-dark → the next slot is lit.
- Disruption mid-frame:
  - drop en in slot 2 → next edge dig=0001, num=20;
  - pulse RST_N low in slot 3 → immediate reset values and snapshot=0;
  - after release, the scan restarts at digit 0 SCAN_DIV cycles later.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the display path.
//   BLANK_CODE_D / NUM_W_D : default dark-digit code and digit code width
//   scan_st_e              : scanner state (IDLE, SCAN)
//   nibble_count()         : hex digits needed to show a value of given width
package disp_pkg;
  localparam int BLANK_CODE_D = 20;
  localparam int NUM_W_D      = 5;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_st_e;

  function automatic int nibble_count(input int vw);
    return (vw + 3) / 4;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: terminal-count divider, counts 0..DIV-1.
//   CLK, RST_N : clock, async active-low reset
//   en         : count enable
//   clr        : synchronous clear (wins over en)
//   tick       : high during the terminal-count cycle while enabled
module scan_prescaler #(
  parameter int DIV = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == CW'(DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/digit_scanner.sv
// digit_scanner: multiplexed seven-segment display scanner.
//   CLK, RST_N  : clock, async active-low reset
//   en          : scan enable (0 = idle display)
//   load, value : strobe + value captured into the pending register
//   lz_suppress : blank leading zero nibbles (digit 0 always shown)
//   blink       : blink the whole display, BLINK_FRAMES frames per half-period
//   dig         : one-hot digit select, bit 0 = least significant digit
//   num         : code for the selected digit, 0..15 or BLANK_CODE
//   frame_start : one-cycle pulse when digit 0 becomes active
module digit_scanner
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int VALUE_W      = 8,
  parameter int NUM_W        = NUM_W_D,
  parameter int BLANK_CODE   = BLANK_CODE_D,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  en,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  lz_suppress,
  input  logic                  blink,
  output logic [NUM_DIGITS-1:0] dig,
  output logic [NUM_W-1:0]      num,
  output logic                  frame_start
);
  localparam int NIBS = nibble_count(VALUE_W);
  // Nibble view is wide enough for both all value nibbles and every digit slot.
  localparam int MAXN = (NIBS > NUM_DIGITS) ? NIBS : NUM_DIGITS;
  localparam int MAXW = MAXN * 4;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [NUM_W-1:0] BLANK = NUM_W'(BLANK_CODE);

  scan_st_e             state, state_d;
  logic                 tick, wrap, acc;
  logic [IW-1:0]        idx, idx_d, nidx;
  logic [VALUE_W-1:0]   pending, snapshot, snap_d, snap_src;
  logic [MAXW-1:0]      pad_v;
  logic [MAXN-1:0]      lz;
  logic [3:0]           nib;
  logic [NUM_W-1:0]     code, num_d;
  logic [NUM_DIGITS-1:0] dig_d;
  logic                 fs_d, phase, phase_d;
  logic [FW-1:0]        fcnt, fcnt_d;

  // Counting starts the cycle after SCAN is entered, so the first tick lands
  // SCAN_DIV cycles after en is first sampled.
  scan_prescaler #(.DIV(SCAN_DIV)) u_pre (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (en && (state == SCAN)),
    .clr  (!en || (state == IDLE)),
    .tick (tick)
  );

  always_comb begin
    state_d  = en ? SCAN : IDLE;
    wrap     = tick && (idx == IW'(NUM_DIGITS - 1));
    nidx     = wrap ? '0 : idx + IW'(1);
    // On the wrap the next digit-0 code already sees the new snapshot,
    // including a load arriving in the very same cycle.
    snap_src = snapshot;
    if (wrap) snap_src = load ? value : pending;
    pad_v    = MAXW'(snap_src);

    // lz[i]: every nibble at index >= i is zero.
    acc = 1'b1;
    lz  = '0;
    for (int i = MAXN - 1; i >= 0; i--) begin
      acc   = acc & (pad_v[4*i +: 4] == 4'd0);
      lz[i] = acc;
    end

    phase_d = phase;
    fcnt_d  = fcnt;
    if (!blink) begin
      phase_d = 1'b1;
      fcnt_d  = '0;
    end else if (wrap) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = !phase;
      end else begin
        fcnt_d = fcnt + FW'(1);
      end
    end

    nib  = pad_v[4*int'(nidx) +: 4];
    code = NUM_W'(nib);
    if ((int'(nidx) >= NIBS) ||
        (lz_suppress && (nidx != '0) && lz[nidx]) ||
        (blink && !phase_d))
      code = BLANK;

    idx_d  = idx;
    dig_d  = dig;
    num_d  = num;
    fs_d   = 1'b0;
    snap_d = snapshot;
    if (!en) begin
      idx_d   = '0;
      dig_d   = NUM_DIGITS'(1);
      num_d   = BLANK;
      phase_d = 1'b1;
      fcnt_d  = '0;
    end else if (tick) begin
      idx_d  = nidx;
      dig_d  = NUM_DIGITS'(1) << nidx;
      num_d  = code;
      fs_d   = wrap;
      snap_d = snap_src;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      idx         <= '0;
      pending     <= '0;
      snapshot    <= '0;
      phase       <= 1'b1;
      fcnt        <= '0;
      dig         <= NUM_DIGITS'(1);
      num         <= BLANK;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      if (load) pending <= value;
      snapshot    <= snap_d;
      phase       <= phase_d;
      fcnt        <= fcnt_d;
      dig         <= dig_d;
      num         <= num_d;
      frame_start <= fs_d;
    end
  end
endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: directed bench for digit_scanner.
//   u0: 4 digits, 8-bit value, SCAN_DIV=2, BLINK_FRAMES=2
//   u1: 6 digits, 16-bit value, SCAN_DIV=2
module tb_digit_scanner;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  logic        en0 = 0, load0 = 0, lz0 = 0, blink0 = 0;
  logic [7:0]  value0 = '0;
  logic [3:0]  dig0;
  logic [4:0]  num0;
  logic        fs0;

  logic        en1 = 0, load1 = 0, lz1 = 0, blink1 = 0;
  logic [15:0] value1 = '0;
  logic [5:0]  dig1;
  logic [4:0]  num1;
  logic        fs1;

  digit_scanner #(.NUM_DIGITS(4), .VALUE_W(8), .SCAN_DIV(2), .BLINK_FRAMES(2)) u0 (
    .CLK(CLK), .RST_N(RST_N), .en(en0), .load(load0), .value(value0),
    .lz_suppress(lz0), .blink(blink0), .dig(dig0), .num(num0), .frame_start(fs0));

  digit_scanner #(.NUM_DIGITS(6), .VALUE_W(16), .SCAN_DIV(2), .BLINK_FRAMES(32)) u1 (
    .CLK(CLK), .RST_N(RST_N), .en(en1), .load(load1), .value(value1),
    .lz_suppress(lz1), .blink(blink1), .dig(dig1), .num(num1), .frame_start(fs1));

  int checks = 0;
  int errors = 0;
  int ex[6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] gdig(input bit sel);
    return sel ? 8'(dig1) : 8'(dig0);
  endfunction
  function automatic logic [4:0] gnum(input bit sel);
    return sel ? num1 : num0;
  endfunction
  function automatic logic gfs(input bit sel);
    return sel ? fs1 : fs0;
  endfunction

  // Steps until the next frame_start pulse (at least one step).
  task automatic wait_fs(input bit sel);
    int n = 0;
    do begin
      step();
      n++;
    end while (!gfs(sel) && n < 200);
    if (!gfs(sel)) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  // Called one step after a frame_start edge; checks every cycle of the frame
  // against ex[] and returns one step after the next frame_start edge.
  task automatic check_frame(input bit sel);
    int n = sel ? 6 : 4;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("u%0d_dig%0d_c%0d", sel, s, c), 32'(gdig(sel)), 32'(1) << s);
        chk($sformatf("u%0d_num%0d_c%0d", sel, s, c), 32'(gnum(sel)), 32'(ex[s]));
        chk($sformatf("u%0d_fs%0d_c%0d", sel, s, c), 32'(gfs(sel)), 32'((s == 0 && c == 0) ? 1 : 0));
        step();
      end
    end
  endtask

  initial begin
    int fs_seen;
    // Reset and idle
    #1 RST_N = 1'b0;
    #1;
    chk("rst_dig", 32'(dig0), 32'h1);
    chk("rst_num", 32'(num0), 32'd20);
    chk("rst_fs",  32'(fs0),  32'd0);
    step(); step();
    RST_N = 1'b1;
    fs_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fs0) fs_seen++;
    end
    chk("idle_fs_count", 32'(fs_seen), 32'd0);
    chk("idle_dig", 32'(dig0), 32'h1);
    chk("idle_num", 32'(num0), 32'd20);

    // Basic scan
    value0 = 8'hA5; load0 = 1; step(); load0 = 0;
    en0 = 1;
    step(); chk("pre_tick_dig", 32'(dig0), 32'h1);
    step(); chk("pre_tick_dig2", 32'(dig0), 32'h1);
    step(); chk("first_tick_dig", 32'(dig0), 32'h2);
    chk("first_tick_num", 32'(num0), 32'd0);
    wait_fs(0);
    ex = '{5, 10, 20, 20, 0, 0};
    check_frame(0);

    // Tearing: mid-frame load keeps the old snapshot until next frame
    value0 = 8'h12; load0 = 1; step(); load0 = 0;
    step();
    chk("tear_dig", 32'(dig0), 32'h2);
    chk("tear_num", 32'(num0), 32'd10);
    wait_fs(0);
    ex = '{2, 1, 20, 20, 0, 0};
    check_frame(0);

    // Load on the wrap cycle bypasses pending
    for (int i = 0; i < 7; i++) step();
    value0 = 8'h72; load0 = 1; step(); load0 = 0;
    chk("bypass_fs",  32'(fs0),  32'd1);
    chk("bypass_num", 32'(num0), 32'd2);
    ex = '{2, 7, 20, 20, 0, 0};
    check_frame(0);

    // Blink, 2 frames per half-period
    blink0 = 1;
    check_frame(0);
    check_frame(0);
    ex = '{20, 20, 20, 20, 0, 0};
    check_frame(0);
    check_frame(0);
    ex = '{2, 7, 20, 20, 0, 0};
    check_frame(0);
    check_frame(0);
    chk("blink_dark_num", 32'(num0), 32'd20);
    step();
    blink0 = 0;
    step();
    chk("unblink_dig", 32'(dig0), 32'h2);
    chk("unblink_num", 32'(num0), 32'd7);

    // Drop en in slot 2
    step(); step();
    chk("slot2_dig", 32'(dig0), 32'h4);
    en0 = 0;
    step();
    chk("drop_en_dig", 32'(dig0), 32'h1);
    chk("drop_en_num", 32'(num0), 32'd20);
    chk("drop_en_fs",  32'(fs0),  32'd0);
    en0 = 1;
    wait_fs(0);
    check_frame(0);

    // Reset pulse in slot 3
    for (int i = 0; i < 6; i++) step();
    chk("slot3_dig", 32'(dig0), 32'h8);
    RST_N = 1'b0;
    #1;
    chk("midrst_dig", 32'(dig0), 32'h1);
    chk("midrst_num", 32'(num0), 32'd20);
    chk("midrst_fs",  32'(fs0),  32'd0);
    #3 RST_N = 1'b1;
    step(); chk("rel_dig1", 32'(dig0), 32'h1);
    step(); chk("rel_dig2", 32'(dig0), 32'h1);
    step(); chk("rel_dig3", 32'(dig0), 32'h2);
    wait_fs(0);
    ex = '{0, 0, 20, 20, 0, 0};
    check_frame(0);
    en0 = 0;

    // Leading-zero suppression, 6 digits x 16-bit value
    value1 = 16'h0040; lz1 = 1; load1 = 1; step(); load1 = 0;
    en1 = 1;
    wait_fs(1);
    ex = '{0, 4, 20, 20, 20, 20};
    check_frame(1);
    value1 = 16'h0000; load1 = 1; step(); load1 = 0;
    wait_fs(1);
    ex = '{0, 20, 20, 20, 20, 20};
    check_frame(1);
    value1 = 16'h0040; lz1 = 0; load1 = 1; step(); load1 = 0;
    wait_fs(1);
    ex = '{0, 4, 0, 0, 20, 20};
    check_frame(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
